shift_accum: RTL and testbench
==============================

SHIFT_ACCUM -- requirements
Module: shift_accum

Interface
REQ-001 Parameter W, default 16: barrel input sample width; the data input is 2*W bits.
REQ-002 Parameter GUARD, default 8: accumulator guard bits; ACC_W = 2*W+GUARD.
REQ-003 Parameter MAX_LEN, default 255: maximum beats per frame, range 1..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  in_data/in_last valid this cycle.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_data  input  2*W  signed two's-complement shifted sample from the barrel shifter stage.
REQ-009 in_last  input  1  marks the final beat of a frame.
REQ-010 out_valid  output  1  frame result available.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 out_data  output  ACC_W  signed frame sum, saturated.
REQ-013 out_count  output  8  number of beats summed in the frame.
REQ-014 out_sat  output  1  sticky: saturation occurred during the frame.
REQ-015 out_trunc  output  1  frame was closed at MAX_LEN without in_last.

Function
REQ-016 A beat is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-017 FSM states: IDLE (no frame open), ACCUM (frame open), HOLD (result presented).
REQ-018 IDLE: in_ready=1; an accepted beat loads acc=sign-extended in_data, sets cnt=1, and moves to ACCUM, or to HOLD if it closes the frame (REQ-021).
REQ-019 ACCUM: in_ready=1; an accepted beat sets acc=sat(acc+sext(in_data)) and increments cnt; without an accepted beat, state and registers hold.
REQ-020 Addition is computed at ACC_W+1 bits. On overflow, acc clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1) and the sticky sat flag sets.
REQ-021 A frame closes on the accepted beat that has in_last=1, or on the accepted beat that brings cnt to MAX_LEN; trunc=1 only if it closed at MAX_LEN with in_last=0.
REQ-022 A closing beat moves the FSM to HOLD. out_valid=1 in the next cycle (1-cycle latency), and out_data/out_count/out_sat/out_trunc are registered and stable while in HOLD.
REQ-023 HOLD: in_ready=0 and out_valid=1. When out_ready=1, the FSM returns to IDLE next cycle and acc, cnt, sat and trunc clear.
REQ-024 out_valid=0 outside HOLD; out_data, out_count, out_sat and out_trunc are 0 outside HOLD.
REQ-025 A single-beat frame (in_last=1 accepted in IDLE) gives out_count=1 and out_data=sext(in_data).
REQ-026 out_ready asserted outside HOLD is ignored.
REQ-027 in_ready depends only on state (registered), not combinationally on in_valid or out_ready.

Reset
REQ-028 rst_n=0 asynchronously forces state=IDLE and acc, cnt, sat and trunc to 0.
REQ-029 During reset: in_ready=1 and out_valid=0, with all data outputs 0.
REQ-030 Reset mid-frame or in HOLD discards the partial frame or pending result; no output is produced for it.
REQ-031 The first beat is acceptable on the first rising edge after rst_n deasserts.

Structure
REQ-032 A shared DSP package holds the FSM state enum (IDLE/ACCUM/HOLD), the default W and GUARD, and the saturating-add helper/constants.
REQ-033 One sub-module, sat_add (ACC_W-wide signed add with clamp and overflow flag), is instantiated once.
REQ-034 No memories; all state is flops.

Verification
REQ-035 Frame of in_data = 5, -3, 10 (last on 10) with out_ready=1 -> out_valid one cycle after the third beat, out_data=12, out_count=3, out_sat=0, out_trunc=0.
REQ-036 GUARD=0, W=16: two beats of 0x7FFF_FFFF, the second with in_last -> out_data=0x7FFF_FFFF, out_sat=1; the next frame of 1 (last) -> out_sat=0, out_data=1.
REQ-037 MAX_LEN=4: six beats of 1, in_last never set -> first result out_data=4, out_count=4, out_trunc=1; a second frame opens with beat 5.
REQ-038 Frame closed with out_ready=0 for 3 cycles -> in_ready=0 and outputs stable for 3 cycles; out_ready=1 -> IDLE next cycle and in_ready=1.
REQ-039 rst_n pulsed low after 2 beats of a frame -> immediate in_ready=1, out_valid=0; a subsequent single beat 7 with in_last -> out_data=7, out_count=1.
REQ-040 Single-beat frame in_data=-1 (all ones) with in_last -> out_data=-1 sign-extended to ACC_W, out_count=1.

Source files
------------

// File: rtl/shift_accum_pkg.sv
// Shared definitions for the shift-accumulate stage: FSM states, default
// widths, and the overflow classifier used by the saturating adder.
package shift_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_W     = 16;
    localparam int DEF_GUARD = 8;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_POS  = 2'd1,
        SAT_NEG  = 2'd2
    } sat_t;

    // carry_msb is the true sign of the one-bit-wider sum; a disagreement
    // with the narrow sign bit means the result left the representable range.
    function automatic sat_t sat_kind(input logic carry_msb, input logic sum_msb);
        sat_t kind;
        if (carry_msb == sum_msb) begin
            kind = SAT_NONE;
        end else if (carry_msb) begin
            kind = SAT_NEG;
        end else begin
            kind = SAT_POS;
        end
        return kind;
    endfunction

endpackage

// File: rtl/shift_accum_sat_add.sv
// Signed ACC_W-bit adder that clamps to the most positive/negative value on
// overflow and flags it.
module sat_add
    import shift_accum_pkg::*;
#(
    parameter int ACC_W = 40
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);

    localparam logic [ACC_W-1:0] POS_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] NEG_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] wide_s;
    sat_t           kind_s;

    // Widen by one bit, add, then clamp according to the overflow direction.
    always_comb begin
        wide_s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        kind_s = sat_kind(wide_s[ACC_W], wide_s[ACC_W-1]);
        sum    = wide_s[ACC_W-1:0];
        ovf    = 1'b0;
        case (kind_s)
            SAT_POS: begin
                sum = POS_MAX;
                ovf = 1'b1;
            end
            SAT_NEG: begin
                sum = NEG_MIN;
                ovf = 1'b1;
            end
            default: begin
                sum = wide_s[ACC_W-1:0];
                ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_accum.sv
// Frame accumulator behind the barrel shifter: sums signed beats with
// saturation and presents one registered result per frame.
module shift_accum
    import shift_accum_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int GUARD   = DEF_GUARD,
    parameter int MAX_LEN = 255,
    localparam int ACC_W  = 2*W + GUARD
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*W-1:0]          in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic [7:0]              out_count,
    output logic                    out_sat,
    output logic                    out_trunc
);

    localparam logic [7:0] MAX_C = 8'(MAX_LEN);

    state_t                  state_r, state_next_s;
    logic signed [ACC_W-1:0] acc_r, acc_next_s;
    logic [7:0]              cnt_r, cnt_next_s;
    logic                    sat_r, sat_next_s;
    logic                    trunc_r, trunc_next_s;

    logic signed [ACC_W-1:0] in_ext_s;
    logic signed [ACC_W-1:0] sum_s;
    logic                    ovf_s;
    logic                    accept_s;
    logic                    hold_next_s;

    assign in_ext_s = ACC_W'($signed(in_data));
    assign accept_s = in_valid && in_ready;

    sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .a   (acc_r),
        .b   (in_ext_s),
        .sum (sum_s),
        .ovf (ovf_s)
    );

    // Next-state and next-register values for the frame FSM.
    always_comb begin
        state_next_s = state_r;
        acc_next_s   = acc_r;
        cnt_next_s   = cnt_r;
        sat_next_s   = sat_r;
        trunc_next_s = trunc_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    acc_next_s   = in_ext_s;
                    cnt_next_s   = 8'd1;
                    sat_next_s   = 1'b0;
                    trunc_next_s = 1'b0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s) begin
                    acc_next_s = sum_s;
                    cnt_next_s = cnt_r + 8'd1;
                    sat_next_s = sat_r | ovf_s;
                end else begin
                    state_next_s = ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                    acc_next_s   = {ACC_W{1'b0}};
                    cnt_next_s   = 8'd0;
                    sat_next_s   = 1'b0;
                    trunc_next_s = 1'b0;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = IDLE;
                acc_next_s   = {ACC_W{1'b0}};
                cnt_next_s   = 8'd0;
                sat_next_s   = 1'b0;
                trunc_next_s = 1'b0;
            end
        endcase

        // in_ready is only high in IDLE/ACCUM, so accept_s implies one of them.
        if (accept_s) begin
            if (in_last || (cnt_next_s == MAX_C)) begin
                state_next_s = HOLD;
                trunc_next_s = !in_last;
            end else begin
                state_next_s = ACCUM;
            end
        end else begin
            trunc_next_s = trunc_next_s;
        end

        hold_next_s = (state_next_s == HOLD);
    end

    // FSM state and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= 8'd0;
            sat_r   <= 1'b0;
            trunc_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            acc_r   <= acc_next_s;
            cnt_r   <= cnt_next_s;
            sat_r   <= sat_next_s;
            trunc_r <= trunc_next_s;
        end
    end

    // Output registers track the next state so results appear one cycle after the closing beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= {ACC_W{1'b0}};
            out_count <= 8'd0;
            out_sat   <= 1'b0;
            out_trunc <= 1'b0;
        end else begin
            in_ready  <= !hold_next_s;
            out_valid <= hold_next_s;
            out_data  <= hold_next_s ? acc_next_s : {ACC_W{1'b0}};
            out_count <= hold_next_s ? cnt_next_s : 8'd0;
            out_sat   <= hold_next_s ? sat_next_s : 1'b0;
            out_trunc <= hold_next_s ? trunc_next_s : 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_accum.sv
// Directed bench for shift_accum: default, GUARD=0 and MAX_LEN=4 instances
// share one stimulus stream; each scenario checks the instance it targets.
module tb_shift_accum;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [31:0] in_data;

    logic        d_in_ready, d_out_valid, d_out_sat, d_out_trunc;
    logic [39:0] d_out_data;
    logic [7:0]  d_out_count;

    logic        g_in_ready, g_out_valid, g_out_sat, g_out_trunc;
    logic [31:0] g_out_data;
    logic [7:0]  g_out_count;

    logic        m_in_ready, m_out_valid, m_out_sat, m_out_trunc;
    logic [39:0] m_out_data;
    logic [7:0]  m_out_count;

    int checks;
    int failures;

    shift_accum #(.W(16), .GUARD(8), .MAX_LEN(255)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(d_out_valid),
        .out_ready(out_ready), .out_data(d_out_data), .out_count(d_out_count),
        .out_sat(d_out_sat), .out_trunc(d_out_trunc)
    );

    shift_accum #(.W(16), .GUARD(0), .MAX_LEN(255)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(g_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(g_out_valid),
        .out_ready(out_ready), .out_data(g_out_data), .out_count(g_out_count),
        .out_sat(g_out_sat), .out_trunc(g_out_trunc)
    );

    shift_accum #(.W(16), .GUARD(8), .MAX_LEN(4)) dut_m4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(m_out_valid),
        .out_ready(out_ready), .out_data(m_out_data), .out_count(m_out_count),
        .out_sat(m_out_sat), .out_trunc(m_out_trunc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'd0;
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        clk       = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        in_data   = 32'd0;

        repeat (2) step();
        chk("rst_in_ready", d_in_ready, 1'b1);
        chk("rst_out_valid", d_out_valid, 1'b0);
        chk("rst_out_data", d_out_data, 40'd0);
        chk("rst_out_count", d_out_count, 8'd0);
        rst_n = 1'b1;

        // 5, -3, 10 frame with out_ready held high throughout
        out_ready = 1'b1;
        beat(32'd5, 1'b0);
        beat(32'hFFFF_FFFD, 1'b0);
        chk("f1_open_valid", d_out_valid, 1'b0);
        chk("f1_open_ready", d_in_ready, 1'b1);
        beat(32'd10, 1'b1);
        chk("f1_valid", d_out_valid, 1'b1);
        chk("f1_data", d_out_data, 40'd12);
        chk("f1_count", d_out_count, 8'd3);
        chk("f1_sat", d_out_sat, 1'b0);
        chk("f1_trunc", d_out_trunc, 1'b0);
        chk("f1_in_ready", d_in_ready, 1'b0);
        step();
        chk("f1_idle_valid", d_out_valid, 1'b0);
        chk("f1_idle_ready", d_in_ready, 1'b1);
        chk("f1_idle_data", d_out_data, 40'd0);
        out_ready = 1'b0;

        // GUARD=0 positive saturation, then sat clears on next frame
        rst_pulse();
        beat(32'h7FFF_FFFF, 1'b0);
        beat(32'h7FFF_FFFF, 1'b1);
        chk("g0_valid", g_out_valid, 1'b1);
        chk("g0_data", g_out_data, 32'h7FFF_FFFF);
        chk("g0_sat", g_out_sat, 1'b1);
        chk("g0_count", g_out_count, 8'd2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        beat(32'd1, 1'b1);
        chk("g0_next_data", g_out_data, 32'd1);
        chk("g0_next_sat", g_out_sat, 1'b0);

        // MAX_LEN=4 truncation and reopening
        rst_pulse();
        repeat (4) beat(32'd1, 1'b0);
        chk("m4_valid", m_out_valid, 1'b1);
        chk("m4_data", m_out_data, 40'd4);
        chk("m4_count", m_out_count, 8'd4);
        chk("m4_trunc", m_out_trunc, 1'b1);
        chk("m4_in_ready", m_in_ready, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        beat(32'd1, 1'b0);
        beat(32'd1, 1'b0);
        chk("m4_reopen_valid", m_out_valid, 1'b0);
        chk("m4_reopen_ready", m_in_ready, 1'b1);
        beat(32'd1, 1'b1);
        chk("m4_f2_data", m_out_data, 40'd3);
        chk("m4_f2_count", m_out_count, 8'd3);
        chk("m4_f2_trunc", m_out_trunc, 1'b0);

        // Back-pressure: result held for 3 cycles
        rst_pulse();
        beat(32'd4, 1'b0);
        beat(32'd6, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_in_ready", d_in_ready, 1'b0);
            chk("bp_valid", d_out_valid, 1'b1);
            chk("bp_data", d_out_data, 40'd10);
            chk("bp_count", d_out_count, 8'd2);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_valid", d_out_valid, 1'b0);
        chk("bp_release_ready", d_in_ready, 1'b1);

        // Reset mid-frame discards it
        rst_pulse();
        beat(32'd100, 1'b0);
        beat(32'd200, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("midrst_in_ready", d_in_ready, 1'b1);
        chk("midrst_valid", d_out_valid, 1'b0);
        chk("midrst_data", d_out_data, 40'd0);
        step();
        rst_n = 1'b1;
        beat(32'd7, 1'b1);
        chk("midrst_f_data", d_out_data, 40'd7);
        chk("midrst_f_count", d_out_count, 8'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Single beat of -1 sign-extends to full width
        beat(32'hFFFF_FFFF, 1'b1);
        chk("neg1_data", d_out_data, 40'hFF_FFFF_FFFF);
        chk("neg1_count", d_out_count, 8'd1);
        chk("neg1_g0_data", g_out_data, 32'hFFFF_FFFF);

        // Negative saturation at GUARD=0; guard bits absorb it in the default instance
        rst_pulse();
        beat(32'h8000_0000, 1'b0);
        beat(32'h8000_0000, 1'b1);
        chk("negsat_g0_data", g_out_data, 32'h8000_0000);
        chk("negsat_g0_sat", g_out_sat, 1'b1);
        chk("negsat_def_data", d_out_data, 40'hFF_0000_0000);
        chk("negsat_def_sat", d_out_sat, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
